// File: rtl/seg7_scan_if.sv
// Signal bundle between the key decoder / board pins and seg7_scan_ctrl.
// The master side drives key strobes; the slave side is the scan controller.
interface seg7_scan_if #(
  parameter int NDIG = 4
);
  logic              key_valid;
  logic [3:0]        key_code;
  logic              clr;
  logic [7:0]        seg;
  logic [NDIG-1:0]   dig_sel;
  logic [4*NDIG-1:0] buf_out;
  logic [NDIG-1:0]   valid_out;
  logic              frame_tick;

  modport master (
    output key_valid, key_code, clr,
    input  seg, dig_sel, buf_out, valid_out, frame_tick
  );

  modport slave (
    input  key_valid, key_code, clr,
    output seg, dig_sel, buf_out, valid_out, frame_tick
  );
endinterface

// File: rtl/seg7_scan_ctrl.sv
// Multiplexed 7-segment controller: key-entry digit shift register plus
// a blank/drive scan over NDIG digits on a shared active-low segment bus.
//
// state | meaning
// BLANK | all digit enables off so segment lines settle between digits
// DRIVE | digit idx enabled, showing its pattern (dark if never entered)
module seg7_scan_ctrl #(
  parameter int NDIG      = 4,
  parameter int SLOT_CYC  = 50000,
  parameter int BLANK_CYC = 500
) (
  input  logic clk,
  input  logic rst,
  seg7_scan_if.slave bus
);

  localparam int CW = (SLOT_CYC > 2) ? $clog2(SLOT_CYC) : 1;
  localparam int IW = $clog2(NDIG);
  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYC - 1);
  localparam logic [CW-1:0] DRIVE_LAST = CW'(SLOT_CYC - BLANK_CYC - 1);
  localparam logic [IW-1:0] IDX_LAST   = IW'(NDIG - 1);

  typedef enum logic {BLANK, DRIVE} state_t;

  state_t            state_q, state_nx;
  logic [CW-1:0]     cnt_q, cnt_nx;
  logic [IW-1:0]     idx_q, idx_nx;
  logic              wrap;

  logic [4*NDIG-1:0] buf_q;
  logic [NDIG-1:0]   valid_q;

  logic [7:0]        seg_q, seg_nx;
  logic [NDIG-1:0]   dig_sel_q, dig_sel_nx;
  logic              frame_tick_q;
  logic [3:0]        cur_code;

  function automatic logic [7:0] hex_seg(input logic [3:0] h);
    logic [7:0] p;
    case (h)
      4'h0: p = 8'hC0;
      4'h1: p = 8'hF9;
      4'h2: p = 8'hA4;
      4'h3: p = 8'hB0;
      4'h4: p = 8'h99;
      4'h5: p = 8'h92;
      4'h6: p = 8'h82;
      4'h7: p = 8'hF8;
      4'h8: p = 8'h80;
      4'h9: p = 8'h98;
      4'hA: p = 8'h88;
      4'hB: p = 8'h83;
      4'hC: p = 8'hA7;
      4'hD: p = 8'hA1;
      4'hE: p = 8'h86;
      default: p = 8'h8E;
    endcase
    return p;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= BLANK;
      cnt_q   <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_nx;
      cnt_q   <= cnt_nx;
      idx_q   <= idx_nx;
    end
  end

  always_comb begin
    state_nx = state_q;
    cnt_nx   = cnt_q + CW'(1);
    idx_nx   = idx_q;
    wrap     = 1'b0;
    case (state_q)
      BLANK: begin
        if (cnt_q == BLANK_LAST) begin
          state_nx = DRIVE;
          cnt_nx   = '0;
        end
      end
      DRIVE: begin
        if (cnt_q == DRIVE_LAST) begin
          state_nx = BLANK;
          cnt_nx   = '0;
          if (idx_q == IDX_LAST) begin
            idx_nx = '0;
            wrap   = 1'b1;
          end else begin
            idx_nx = idx_q + IW'(1);
          end
        end
      end
      default: begin
        state_nx = BLANK;
        cnt_nx   = '0;
        idx_nx   = '0;
      end
    endcase
  end

  // Outputs decode the upcoming scan position so they line up with the
  // state register, but use the current (registered) digit contents.
  always_comb begin
    seg_nx     = 8'hFF;
    dig_sel_nx = '1;
    cur_code   = buf_q[{idx_nx, 2'b00} +: 4];
    if (state_nx == DRIVE) begin
      dig_sel_nx = ~(NDIG'(1) << idx_nx);
      if (valid_q[idx_nx]) seg_nx = hex_seg(cur_code);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      seg_q        <= 8'hFF;
      dig_sel_q    <= '1;
      frame_tick_q <= 1'b0;
    end else begin
      seg_q        <= seg_nx;
      dig_sel_q    <= dig_sel_nx;
      frame_tick_q <= wrap;
    end
  end

  // Oldest digit falls off the left end once all NDIG positions are used.
  always_ff @(posedge clk) begin
    if (rst || bus.clr) begin
      buf_q   <= '0;
      valid_q <= '0;
    end else if (bus.key_valid) begin
      buf_q   <= {buf_q[4*NDIG-5:0], bus.key_code};
      valid_q <= {valid_q[NDIG-2:0], 1'b1};
    end
  end

  assign bus.seg        = seg_q;
  assign bus.dig_sel    = dig_sel_q;
  assign bus.buf_out    = buf_q;
  assign bus.valid_out  = valid_q;
  assign bus.frame_tick = frame_tick_q;

endmodule

// File: doc/seg7_scan_ctrl.md
Name: seg7_scan_ctrl

Overview:
- Multi-digit 7-segment display controller for the key-entry shift-register experiment.
- Holds the last NDIG hex key codes in a digit shift register.
- Time-multiplexes those digits onto one shared active-low segment bus, with a per-slot anti-ghosting blank interval.
- Sits between the matrix-key decoder (single-cycle key strobes) and the board's segment/digit-enable pins.

Parameters:
- NDIG, 4: number of digits (2..8).
- SLOT_CYC, 50000: clk cycles per digit slot (1 kHz slot rate at 50 MHz); must be > BLANK_CYC.
- BLANK_CYC, 500: cycles at the start of each slot with all digits disabled; must be >= 1.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- key_valid  in  1  one-cycle strobe: key_code is a new entry.
- key_code  in  4  hex code of the pressed key.
- clr  in  1  one-cycle strobe: erase all stored digits.
- seg  out  8  active-low segments, bit7 = DP (always 1 = off), bits6..0 = g..a.
- dig_sel  out  NDIG  active-low digit enables, at most one bit low; bit 0 = rightmost digit.
- buf_out  out  4*NDIG  stored codes, digit i at [4i+3:4i].
- valid_out  out  NDIG  per-digit "entered" flags.
- frame_tick  out  1  one-cycle pulse when the scan wraps from digit NDIG-1 to digit 0.

Behaviour:
- Interface (already decided): one clock, clk. Reset rst is synchronous and active-high.

Reset (clk edge with rst=1):
- Slot counter = 0, idx = 0, state = BLANK.
- buf_out = 0, valid_out = 0.
- seg = 8'hFF, dig_sel = all ones, frame_tick = 0.
- rst overrides every other input. Reset mid-scan restarts at digit 0, BLANK, count 0.

Entry shift register (update visible the cycle after the strobe):
- clr=1 → buf_out = 0, valid_out = 0. clr wins over a simultaneous key_valid.
- key_valid=1, clr=0 → buf_out = {buf_out[4*NDIG-5:0], key_code}; valid_out = {valid_out[NDIG-2:0], 1'b1}.
- When full, the oldest (leftmost) digit is discarded; there is no overflow flag.
- Key strobes are accepted in any scan state; the scan timing is unaffected by them.

Scan FSM, states BLANK and DRIVE, slot counter cnt:
- BLANK: cnt counts 0..BLANK_CYC-1. At cnt==BLANK_CYC-1 → DRIVE, cnt=0.
- DRIVE: cnt counts 0..SLOT_CYC-BLANK_CYC-1. At the terminal count → BLANK, cnt=0, idx = (idx==NDIG-1) ? 0 : idx+1.
- frame_tick is registered: it is 1 in the first BLANK cycle of digit 0 after a wrap, and 0 otherwise (including after reset).
- Slot period is exactly SLOT_CYC cycles; frame period is NDIG*SLOT_CYC cycles.

Outputs are a registered Moore decode of {state, idx, buf_out, valid_out}, with no extra latency beyond the register:
- BLANK: seg = 8'hFF, dig_sel = all ones.
- DRIVE: dig_sel = ~(1<<idx).
  - If valid_out[idx]=1, seg = hex pattern of digit idx.
  - If valid_out[idx]=0, seg = 8'hFF (unentered digits dark).
- Hex patterns: 0=C0, 1=F9, 2=A4, 3=B0, 4=99, 5=92, 6=82, 7=F8, 8=80, 9=98, A=88, b=83, C=A7, d=A1, E=86, F=8E.
- A key or clr during DRIVE changes seg within the same slot, one cycle after buf_out changes.
- dig_sel and seg never show a new digit enable together with the previous digit's pattern, because the blank interval always separates slots.

Test Plan (NDIG=4, SLOT_CYC=8, BLANK_CYC=2):
1. Reset, then idle 64 cycles → seg=FF throughout. dig_sel low pattern E,D,B,7 for 6 cycles each, separated by 2-cycle all-ones gaps. frame_tick pulses every 32 cycles.
2. Keys 1,2,3 as single strobes → buf_out=16'h0123, valid_out=4'b0111. Digit0 slot seg=B0, digit1 slot A4, digit2 slot F9, digit3 slot FF with dig_sel=7.
3. Keys 1,2,3,4,5 → buf_out=16'h2345, valid_out=4'b1111 (the 1 is discarded). Digit3 slot shows seg=A4.
4. clr and key_valid (code A) in the same cycle after buf_out=16'h2345 → next cycle buf_out=0, valid_out=0. All slots show seg=FF.
5. Key F strobed during the digit0 DRIVE phase → seg changes from FF to 8E one cycle after buf_out changes, and dig_sel is unchanged.
6. rst asserted during the digit2 DRIVE phase with entries present → next cycle seg=FF, dig_sel=F, buf_out=0. The scan restarts at digit 0 with 2 blank cycles, and the first frame_tick arrives 32 cycles later.
